// File: rtl/inv_addround_ctrl.sv
// Inverse AddRoundKey sequencer: streams 16 state bytes per pass, XORing each with a
// synchronously-read subkey byte, walking round keys from NUM_ROUNDS down to 0.
module inv_addround_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] key_addr,
  input  logic [7:0] key_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic [3:0] round_out,
  output logic       busy,
  output logic       done
);

  localparam int unsigned RW = 4;
  localparam int unsigned BW = 4;
  localparam logic [RW-1:0] ROUND_RELOAD = RW'(NUM_ROUNDS);
  localparam logic [BW-1:0] LAST_BYTE    = BW'(15);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_XFER  = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  state_e        state_q;
  logic [BW-1:0] byte_idx_q;
  logic [RW-1:0] round_q;
  logic          out_valid_q;
  logic [7:0]    out_data_q;
  logic          done_q;
  logic          accept_c;

  // A new byte may enter only when the output slot is empty or draining this cycle.
  assign in_ready  = (state_q == S_XFER) && (!out_valid_q || out_ready);
  assign accept_c  = in_valid && in_ready;

  assign key_addr  = {round_q, byte_idx_q};
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign round_out = round_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      byte_idx_q  <= '0;
      round_q     <= ROUND_RELOAD;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Output slot: a fresh byte overrides a simultaneous drain.
      if (accept_c) begin
        out_data_q  <= in_data ^ key_data;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_FETCH;
            byte_idx_q <= '0;
          end
        end
        S_FETCH: state_q <= S_XFER;
        S_XFER: begin
          if (accept_c) begin
            byte_idx_q <= byte_idx_q + BW'(1);
            if (byte_idx_q == LAST_BYTE) begin
              state_q <= S_FIN;
              // Round 0 closes the decryption; wrap back to the first key.
              if (round_q == '0) begin
                round_q <= ROUND_RELOAD;
                done_q  <= 1'b1;
              end else begin
                round_q <= round_q - RW'(1);
              end
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_addround_ctrl.sv
// Scoreboard bench for inv_addround_ctrl: driver pushes expected bytes, a negedge
// monitor pops them on each output handshake and checks hold stability.
module tb_inv_addround_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [7:0] key_addr;
  logic [7:0] key_data = 8'h00;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b1;
  logic [3:0] round_out;
  logic       busy;
  logic       done;

  inv_addround_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .key_addr(key_addr), .key_data(key_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .round_out(round_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Key store: mem[{r,i}] = {r,i} unless overridden; one-cycle synchronous read.
  logic [7:0] kmem [256];
  always @(posedge clk) key_data <= kmem[key_addr];

  int         checks = 0;
  int         failures = 0;
  int         done_cnt = 0;
  logic [7:0] exp_q [$];
  logic [3:0] exp_round = 4'd10;
  logic       hold = 1'b0;
  logic [7:0] hold_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: consume one expected byte per output handshake.
  always @(negedge clk) begin
    if (!n_rst) begin
      hold = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (hold) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(hold_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: got %0h expected none at %0t", out_data, $time);
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
      hold      = out_valid && !out_ready;
      hold_data = out_data;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic [3:0] idx);
    logic [7:0] a;
    a        = {exp_round, idx};
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (in_ready) begin
        chk("key_addr", 32'(key_addr), 32'(a));
        exp_q.push_back(d ^ kmem[a]);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic start_pass();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic run_pass(input logic [7:0] d [16], input bit bp, input bit spulse);
    logic [3:0] nr;
    start_pass();
    for (int i = 0; i < 16; i++) begin
      if (spulse && i == 5) start = 1'b1;
      send_byte(d[i], 4'(i));
      start = 1'b0;
      if (bp && i == 0) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = d[1];
        repeat (6) begin
          @(negedge clk);
          chk("bp_in_ready", 32'(in_ready), 32'd0);
          chk("bp_out_valid", 32'(out_valid), 32'd1);
          chk("bp_key_addr", 32'(key_addr), 32'({exp_round, 4'd1}));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    end
    nr = (exp_round == 4'd0) ? 4'd10 : exp_round - 4'd1;
    @(negedge clk);
    chk("fin_done", 32'(done), 32'(exp_round == 4'd0));
    chk("fin_round", 32'(round_out), 32'(nr));
    exp_round = nr;
    @(negedge clk);
    chk("post_done", 32'(done), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    if (spulse) begin
      repeat (3) begin
        @(negedge clk);
        chk("no_queued_start", 32'(busy), 32'd0);
      end
    end
  endtask

  function automatic logic [7:0] pat(input int p, input int i);
    return 8'(p * 37 + i * 11 + 5);
  endfunction

  logic [7:0] buf16 [16];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 256; a++) kmem[a] = 8'(a);

    #2 n_rst = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_round", 32'(round_out), 32'd10);
    chk("rst_key_addr", 32'(key_addr), 32'hA0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 n_rst = 1'b1;

    // Round 10, zero data: outputs A0..AF.
    for (int i = 0; i < 16; i++) buf16[i] = 8'h00;
    run_pass(buf16, 1'b0, 1'b0);

    // Round 9 with backpressure after the first byte.
    for (int i = 0; i < 16; i++) buf16[i] = pat(1, i);
    run_pass(buf16, 1'b1, 1'b0);

    // Round 8 with a stray start mid-pass.
    for (int i = 0; i < 16; i++) buf16[i] = pat(2, i);
    run_pass(buf16, 1'b0, 1'b1);

    // Round 7: XOR corner cases 3C^3C=00 and FF^0F=F0.
    kmem[8'h70] = 8'h3C;
    kmem[8'h71] = 8'h0F;
    for (int i = 0; i < 16; i++) buf16[i] = pat(3, i);
    buf16[0] = 8'h3C;
    buf16[1] = 8'hFF;
    run_pass(buf16, 1'b0, 1'b0);

    // Rounds 6..0; done must pulse only at the end of round 0.
    for (int p = 0; p < 7; p++) begin
      for (int i = 0; i < 16; i++) buf16[i] = pat(4 + p, i);
      run_pass(buf16, 1'b0, 1'b0);
    end
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("round_wrapped", 32'(round_out), 32'd10);

    // Rounds 10..7, then abort round 6 after byte 7 with a pending output.
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 16; i++) buf16[i] = pat(20 + p, i);
      run_pass(buf16, 1'b0, 1'b0);
    end
    chk("pre_abort_round", 32'(round_out), 32'd6);
    start_pass();
    for (int i = 0; i < 8; i++) send_byte(pat(30, i), 4'(i));
    out_ready = 1'b0;
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_data", 32'(out_data), 32'd0);
    chk("abort_round", 32'(round_out), 32'd10);
    chk("abort_busy", 32'(busy), 32'd0);
    exp_q.delete();
    exp_round = 4'd10;
    @(negedge clk);
    #1 n_rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("restart_key_addr", 32'(key_addr), 32'hA0);
    for (int i = 0; i < 16; i++) buf16[i] = pat(40, i);
    run_pass(buf16, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
